// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit for the datapath: Moore outputs decoded from the T-state and ir.
// Optional MEM_WAIT_EN adds a mem_ready input that stretches the memory-access states.
module control_sequencer #(
    parameter logic [4:0] INC_PC_CODE = 5'd14,
    parameter logic [4:0] ADD_CODE    = 5'd3
) (
    input  logic        clk,
    input  logic        clr,
`ifdef MEM_WAIT_EN
    input  logic        mem_ready,
`endif
    input  logic [31:0] ir,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic        MD_Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        ReadRAM,
    output logic        WriteRAM,
    output logic [4:0]  Control_Signals,
    output logic        run,
    output logic [3:0]  o_dbg_state
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] w_op;
    logic       w_mem_ready;
    logic       w_is_rtype, w_is_imm, w_is_ldi, w_is_ld, w_is_st, w_is_jr, w_is_halt;
    logic       w_is_addr, w_is_mem;
    logic [4:0] w_imm_code;

`ifdef MEM_WAIT_EN
    assign w_mem_ready = mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    assign w_op       = ir[31:27];
    assign w_is_rtype = (w_op >= 5'd3) && (w_op <= 5'd11);
    assign w_is_imm   = (w_op >= 5'd12) && (w_op <= 5'd14);
    assign w_is_ld    = (w_op == 5'd0);
    assign w_is_ldi   = (w_op == 5'd1);
    assign w_is_st    = (w_op == 5'd2);
    assign w_is_jr    = (w_op == 5'd20);
    assign w_is_halt  = (w_op == 5'd27);
    assign w_is_mem   = w_is_ld | w_is_st;
    assign w_is_addr  = w_is_ld | w_is_ldi | w_is_st;

    always_comb begin
        case (w_op)
            5'd13:   w_imm_code = 5'd5;
            5'd14:   w_imm_code = 5'd6;
            default: w_imm_code = ADD_CODE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_state <= S_RST;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        enable          = '0;
        busSelect       = '0;
        MD_Read         = 1'b0;
        Gra             = 1'b0;
        Grb             = 1'b0;
        Grc             = 1'b0;
        Rin             = 1'b0;
        Rout            = 1'b0;
        BAout           = 1'b0;
        ReadRAM         = 1'b0;
        WriteRAM        = 1'b0;
        Control_Signals = '0;
        run             = 1'b0;
        case (r_state)
            S_RST: w_next = S_T0;
            S_T0: begin
                run = 1'b1; busSelect[20] = 1'b1; enable[25] = 1'b1; enable[18] = 1'b1;
                Control_Signals = INC_PC_CODE;
                w_next = S_T1;
            end
            S_T1: begin
                run = 1'b1; busSelect[19] = 1'b1; enable[20] = 1'b1; enable[21] = 1'b1;
                MD_Read = 1'b1; ReadRAM = 1'b1;
                if (w_mem_ready) w_next = S_T2;
            end
            S_T2: begin
                run = 1'b1; busSelect[21] = 1'b1; enable[24] = 1'b1;
                w_next = S_T3;
            end
            S_T3: begin
                run = 1'b1;
                if (w_is_rtype || w_is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; enable[16] = 1'b1; w_next = S_T4;
                end else if (w_is_addr) begin
                    Grb = 1'b1; BAout = 1'b1; enable[16] = 1'b1; w_next = S_T4;
                end else if (w_is_jr) begin
                    Gra = 1'b1; Rout = 1'b1; enable[20] = 1'b1; w_next = S_T0;
                end else if (w_is_halt) begin
                    w_next = S_HALT;
                end else begin
                    w_next = S_T0;
                end
            end
            S_T4: begin
                run = 1'b1; enable[18] = 1'b1; w_next = S_T5;
                if (w_is_rtype) begin
                    Grc = 1'b1; Rout = 1'b1; Control_Signals = w_op;
                end else if (w_is_imm) begin
                    busSelect[23] = 1'b1; Control_Signals = w_imm_code;
                end else begin
                    busSelect[23] = 1'b1; Control_Signals = ADD_CODE;
                end
            end
            S_T5: begin
                run = 1'b1; busSelect[19] = 1'b1;
                if (w_is_mem) begin
                    enable[25] = 1'b1; w_next = S_T6;
                end else begin
                    Gra = 1'b1; Rin = 1'b1; w_next = S_T0;
                end
            end
            S_T6: begin
                run = 1'b1; enable[21] = 1'b1;
                if (w_is_st) begin
                    Gra = 1'b1; Rout = 1'b1; w_next = S_T7;
                end else begin
                    MD_Read = 1'b1; ReadRAM = 1'b1;
                    if (w_mem_ready) w_next = S_T7;
                end
            end
            S_T7: begin
                run = 1'b1;
                if (w_is_st) begin
                    WriteRAM = 1'b1;
                    if (w_mem_ready) w_next = S_T0;
                end else begin
                    busSelect[21] = 1'b1; Gra = 1'b1; Rin = 1'b1; w_next = S_T0;
                end
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_RST;
        endcase
        // The general-register bus driver is on whenever select-encode places a register on the bus.
        busSelect[0] = Rout | BAout;
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instruction sequences, per-cycle expected control words
// queued by the driver and checked by a negedge monitor. Define MEM_WAIT_EN to also test wait states.
module tb_control_sequencer;

    logic        clk;
    logic        clr;
    logic [31:0] ir;
    logic [31:0] enable, busSelect;
    logic        MD_Read, Gra, Grb, Grc, Rin, Rout, BAout, ReadRAM, WriteRAM, run;
    logic [4:0]  Control_Signals;
    logic [3:0]  o_dbg_state;
`ifdef MEM_WAIT_EN
    logic        mem_ready;
`endif

    control_sequencer dut (
        .clk(clk), .clr(clr),
`ifdef MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .ir(ir), .enable(enable), .busSelect(busSelect), .MD_Read(MD_Read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .ReadRAM(ReadRAM), .WriteRAM(WriteRAM), .Control_Signals(Control_Signals),
        .run(run), .o_dbg_state(o_dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] EN_Y = 32'h0001_0000, EN_Z = 32'h0004_0000, EN_PC = 32'h0010_0000;
    localparam logic [31:0] EN_MDR = 32'h0020_0000, EN_IR = 32'h0100_0000, EN_MAR = 32'h0200_0000;
    localparam logic [31:0] B_REG = 32'h0000_0001, B_ZLO = 32'h0008_0000, B_PC = 32'h0010_0000;
    localparam logic [31:0] B_MDR = 32'h0020_0000, B_C = 32'h0080_0000;
    // flag order: MD_Read Gra Grb Grc Rin Rout BAout ReadRAM WriteRAM
    localparam logic [8:0] F_MDR = 9'h100, F_GA = 9'h080, F_GB = 9'h040, F_GC = 9'h020, F_RIN = 9'h010;
    localparam logic [8:0] F_ROUT = 9'h008, F_BA = 9'h004, F_RR = 9'h002, F_WR = 9'h001;
    localparam logic [78:0] ZERO = '0;

    logic [78:0] w_act;
    assign w_act = {run, enable, busSelect, MD_Read, Gra, Grb, Grc, Rin, Rout, BAout,
                    ReadRAM, WriteRAM, Control_Signals};

    logic [78:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad = 0;

    function automatic logic [78:0] v(input logic [31:0] en, input logic [31:0] bs,
                                      input logic [8:0] f, input logic [4:0] cs);
        return {1'b1, en, bs, f, cs};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [78:0] e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if (w_act !== e) begin
                bad++;
                $display("FAIL %s: got=%h exp=%h", nm, w_act, e);
            end
        end
    end

    // driver tasks: called at posedge+1, cover one clock cycle
    task automatic step(input logic [78:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string p);
        step(v(EN_MAR | EN_Z, B_PC, 9'h0, 5'd14), {p, "_t0"});
        step(v(EN_PC | EN_MDR, B_ZLO, F_MDR | F_RR, 5'd0), {p, "_t1"});
        step(v(EN_IR, B_MDR, 9'h0, 5'd0), {p, "_t2"});
    endtask

    task automatic addr_t3_t5(input string p);
        step(v(EN_Y, B_REG, F_GB | F_BA, 5'd0), {p, "_t3"});
        step(v(EN_Z, B_C, 9'h0, 5'd3), {p, "_t4"});
        step(v(EN_MAR, B_ZLO, 9'h0, 5'd0), {p, "_t5"});
    endtask

    initial begin
        clr = 1'b0;
        ir  = 32'h0;
`ifdef MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        @(posedge clk); #1;
        step(ZERO, "rst_hold0");
        step(ZERO, "rst_hold1");
        clr = 1'b1;
        step(ZERO, "rst_release");

        // add r1,r2,r3
        ir = 32'h1891_8000;
        fetch("add");
        step(v(EN_Y, B_REG, F_GB | F_ROUT, 5'd0), "add_t3");
        step(v(EN_Z, B_REG, F_GC | F_ROUT, 5'd3), "add_t4");
        step(v(32'h0, B_ZLO, F_GA | F_RIN, 5'd0), "add_t5");

        // ori -> ALU code 6 with Cout
        ir = 32'h7000_0000;
        fetch("ori");
        step(v(EN_Y, B_REG, F_GB | F_ROUT, 5'd0), "ori_t3");
        step(v(EN_Z, B_C, 9'h0, 5'd6), "ori_t4");
        step(v(32'h0, B_ZLO, F_GA | F_RIN, 5'd0), "ori_t5");

        // ldi
        ir = 32'h0880_0010;
        fetch("ldi");
        step(v(EN_Y, B_REG, F_GB | F_BA, 5'd0), "ldi_t3");
        step(v(EN_Z, B_C, 9'h0, 5'd3), "ldi_t4");
        step(v(32'h0, B_ZLO, F_GA | F_RIN, 5'd0), "ldi_t5");

        // ld r1,0x55(r0)
        ir = 32'h0080_0055;
        fetch("ld");
        addr_t3_t5("ld");
        step(v(EN_MDR, 32'h0, F_MDR | F_RR, 5'd0), "ld_t6");
        step(v(32'h0, B_MDR, F_GA | F_RIN, 5'd0), "ld_t7");

        // st
        ir = 32'h1080_0020;
        fetch("st");
        addr_t3_t5("st");
        step(v(EN_MDR, B_REG, F_GA | F_ROUT, 5'd0), "st_t6");
        step(v(32'h0, 32'h0, F_WR, 5'd0), "st_t7");

        // jr r5
        ir = 32'hA280_0000;
        fetch("jr");
        step(v(EN_PC, B_REG, F_GA | F_ROUT, 5'd0), "jr_t3");

        // nop
        ir = 32'hD000_0000;
        fetch("nop");
        step(v(32'h0, 32'h0, 9'h0, 5'd0), "nop_t3");

        // ld interrupted by reset in T6
        ir = 32'h0080_0055;
        fetch("ldr");
        addr_t3_t5("ldr");
        clr = 1'b0;
        step(ZERO, "ldr_t6_async_clr");
        clr = 1'b1;
        step(ZERO, "ldr_rst_release");

        // halt
        ir = 32'hD800_0000;
        fetch("halt");
        step(v(32'h0, 32'h0, 9'h0, 5'd0), "halt_t3");
        for (int i = 0; i < 20; i++) step(ZERO, "halt_idle");
        clr = 1'b0;
        step(ZERO, "halt_clr");
        clr = 1'b1;
        step(ZERO, "halt_rst_release");
        ir = 32'hA280_0000;
        fetch("restart");
        step(v(EN_PC, B_REG, F_GA | F_ROUT, 5'd0), "restart_jr_t3");

`ifdef MEM_WAIT_EN
        // T1 stretched by three not-ready cycles
        ir = 32'hD000_0000;
        step(v(EN_MAR | EN_Z, B_PC, 9'h0, 5'd14), "wait_t0");
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(v(EN_PC | EN_MDR, B_ZLO, F_MDR | F_RR, 5'd0), "wait_t1_hold");
        mem_ready = 1'b1;
        step(v(EN_PC | EN_MDR, B_ZLO, F_MDR | F_RR, 5'd0), "wait_t1_go");
        step(v(EN_IR, B_MDR, 9'h0, 5'd0), "wait_t2");
        step(v(32'h0, 32'h0, 9'h0, 5'd0), "wait_nop_t3");
`endif

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d pending exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives every control input of `datapath`: `enable`, `busSelect`, `MD_Read`, `Gra`/`Grb`/`Grc`, `Rin`, `Rout`, `BAout`, `ReadRAM`, `WriteRAM` and `Control_Signals`.
- Consumes `ir` from the datapath and replaces the hand-sequenced T-state stimulus used in per-instruction benches.
- Runs fetch (T0–T2) then per-opcode execute steps (T3–T7), one state per clock.

Parameters:
- INC_PC_CODE, 14, `Control_Signals` value requesting PC+1 from the ALU.
- ADD_CODE, 3, `Control_Signals` value for address/immediate add.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- clr  in  1  asynchronous, active-low reset
- ir  in  32  instruction register from the datapath: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0]
- enable  out  32  register load enables: 16 Yin, 18 Zin, 20 PCin, 21 MDRin, 24 IRin, 25 MARin; all other bits 0
- busSelect  out  32  bus drivers: 0 general register (via select-encode), 19 ZLOout, 20 PCout, 21 MDRout, 23 Cout
- MD_Read  out  1  MDR input mux selects memory (1) or bus (0)
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  select-encode controls
- ReadRAM, WriteRAM  out  1 each  memory strobes
- Control_Signals  out  5  ALU operation
- run  out  1  1 while executing; 0 in HALT

Behaviour:
- States: RST, T0–T7, HALT. Outputs are Moore, decoded combinationally from the state register and `ir`.
- Any output not listed for a state is 0. All bits of every unused `enable`/`busSelect` position are always 0.
- Reset (`clr` = 0, any time, including mid-instruction):
  - state goes to RST immediately.
  - all outputs 0, `run` = 0.
  - first rising edge after `clr` goes high: RST → T0.
- Fetch, common to all instructions:
  - T0: PCout, MARin, Zin, `Control_Signals` = INC_PC_CODE.
  - T1: ZLOout, PCin, MDRin, `MD_Read` = 1, `ReadRAM` = 1.
  - T2: MDRout, IRin.
- Execute is decoded from `ir[31:27]` in T3 and later. `ir` is stable from T3 onward.
- R-type (opcodes 3–11: add, sub, and, or, ror, rol, shr, shra, shl):
  - T3: `Grb`, `Rout`, Yin.
  - T4: `Grc`, `Rout`, Zin, `Control_Signals` = opcode.
  - T5: ZLOout, `Gra`, `Rin`.
  - then → T0.
- Immediate (12 addi → 3, 13 andi → 5, 14 ori → 6):
  - T3: `Grb`, `Rout`, Yin.
  - T4: Cout, Zin, `Control_Signals` = mapped code.
  - T5: ZLOout, `Gra`, `Rin`.
  - then → T0.
- ldi (1):
  - T3: `Grb`, `BAout`, Yin.
  - T4: Cout, ADD_CODE, Zin.
  - T5: ZLOout, `Gra`, `Rin`.
  - then → T0.
- ld (0):
  - T3–T4 as ldi.
  - T5: ZLOout, MARin.
  - T6: MDRin, `MD_Read` = 1, `ReadRAM` = 1.
  - T7: MDRout, `Gra`, `Rin`.
  - then → T0.
- st (2):
  - T3–T5 as ld.
  - T6: `Gra`, `Rout`, MDRin, `MD_Read` = 0.
  - T7: `WriteRAM` = 1.
  - then → T0.
- jr (20):
  - T3: `Gra`, `Rout`, PCin.
  - then → T0.
- halt (27):
  - T3 → HALT; `run` = 0, all other outputs 0.
  - HALT is left only by reset.
- nop (26) and all other opcodes: T3 drives nothing, then → T0.
- `run` = 1 in T0–T7.
- Instruction length in cycles, including fetch:
  - jr/nop: 4
  - R-type/imm/ldi: 6
  - ld/st: 8

Optional Feature:
- Macro: MEM_WAIT_EN.
- When defined:
  - adds input `mem_ready` (1 bit).
  - states T1 and ld-T6 hold, with outputs unchanged, while `mem_ready` = 0, and advance on the first edge with `mem_ready` = 1.
  - st-T7 holds `WriteRAM` until `mem_ready` = 1.
  - reset still overrides a hold.
- When undefined: no `mem_ready` port; every memory state lasts exactly 1 cycle.

Test Plan:
- Reset: hold `clr` = 0 for 2 cycles, then release → all outputs 0 and `run` = 0 during reset; first released edge enters T0 with `busSelect[20]` = 1, `enable[25]` = 1, `enable[18]` = 1, `Control_Signals` = 14.
- add r1,r2,r3 (`ir` = 0x18918000) → exactly 6 cycles T0–T5; T4 `Control_Signals` = 3 with `Grc`/`Rout`; T5 `busSelect[19]`, `Gra`, `Rin`; next cycle is T0.
- ld r1,0x55(r0) (`ir` = 0x00800055) → 8 cycles; T3 `BAout` = 1; T6 `ReadRAM` = `MD_Read` = 1; T7 `busSelect[21]`, `Gra`, `Rin`.
- jr r5 (`ir` = 0xA2800000) → T3 `Gra`, `Rout`, `enable[20]`; returns to T0 after 4 cycles.
- halt (`ir` = 0xD8000000) → `run` falls after T3 and outputs stay 0 for 20 cycles; `clr` pulse restarts at T0. Also drive `clr` low during ld-T6 → outputs clear asynchronously within the same cycle.
- MEM_WAIT_EN: hold `mem_ready` = 0 for 3 cycles in T1 → `ReadRAM` stays 1 for 4 cycles; T2 follows the cycle after `mem_ready` rises.
